// File: rtl/mem_checker_pkg.sv
// Shared definitions for the memory-checker CSR block: address map, CTRL/STATUS
// bit positions, and the packed parameter/result layouts seen on the core interface.
package mem_checker_pkg;

  localparam int unsigned CTRL_ADDR      = 0;
  localparam int unsigned STATUS_ADDR    = 1;
  localparam int unsigned CSR_1_ADDR     = 2;
  localparam int unsigned CSR_2_ADDR     = 3;
  localparam int unsigned CSR_3_ADDR     = 4;
  localparam int unsigned RES_FIRST_ADDR = 5;
  localparam int unsigned RES_LAST_ADDR  = 14;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_DONE_BIT  = 1;
  localparam int unsigned STATUS_ERROR_BIT = 2;

  // Field order matches the core's packed bus: result_reg in the MSBs.
  typedef struct packed {
    logic [31:0] result_reg;
    logic [31:0] err_cnt_reg;
    logic [31:0] err_addr_reg;
    logic [31:0] err_exp_reg;
    logic [31:0] err_got_reg;
    logic [31:0] wr_cnt_reg;
    logic [31:0] rd_cnt_reg;
    logic [31:0] cycle_cnt_reg;
    logic [31:0] wr_req_reg;
    logic [31:0] rd_req_reg;
  } test_result_t;

  typedef struct packed {
    logic [31:0] csr_1;
    logic [31:0] csr_2;
    logic [31:0] csr_3;
  } test_param_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [31:0] be_merge(logic [31:0] old_val, logic [31:0] new_val,
                                           logic [3:0] be);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

  // Word idx counts from the MSB end, i.e. idx 0 is result_reg.
  function automatic logic [31:0] res_word(test_result_t res, logic [31:0] idx);
    logic [$bits(test_result_t)-1:0] flat;
    flat = res;
    return flat[$bits(test_result_t)-1-32*idx -: 32];
  endfunction

endpackage

// File: rtl/mem_checker_csr.sv
// Avalon-MM CSR slave for the memory checker: test configuration, start/clear
// control, result snapshot on completion, and 1-cycle-latency reads.
module mem_checker_csr #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RES_NUM = 10
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         csr_address_i,
  input  logic                      csr_read_i,
  input  logic                      csr_write_i,
  input  logic [DATA_W-1:0]         csr_writedata_i,
  input  logic [DATA_W/8-1:0]       csr_byteenable_i,
  output logic [DATA_W-1:0]         csr_readdata_o,
  output logic                      csr_readdatavalid_o,
  output logic                      csr_waitrequest_o,
  output logic                      start_o,
  output logic [95:0]               test_param_o,
  input  logic                      test_done_i,
  input  logic [RES_NUM*DATA_W-1:0] test_result_i
);
  import mem_checker_pkg::*;

  state_e       state_q, state_d;
  test_param_t  param_q, param_d;
  test_result_t res_q, res_d;
  logic         start_q, start_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic         rvalid_q;

  logic [31:0] addr;
  logic        addr_is_res;
  logic        wait_req, wr_acc, rd_acc, ctrl_wr, start_req, clear_req;

  assign addr        = 32'(csr_address_i);
  assign addr_is_res = (addr >= RES_FIRST_ADDR) && (addr <= RES_LAST_ADDR);

  // Stall reads of capture-affected registers during the capture edge so they
  // return the post-capture snapshot one cycle later.
  assign wait_req  = csr_read_i && !csr_write_i && test_done_i &&
                     ((addr == STATUS_ADDR) || addr_is_res);
  assign wr_acc    = csr_write_i && !wait_req;
  assign rd_acc    = csr_read_i && !csr_write_i && !wait_req;
  assign ctrl_wr   = wr_acc && (addr == CTRL_ADDR) && csr_byteenable_i[0];
  assign start_req = ctrl_wr && csr_writedata_i[CTRL_START_BIT];
  assign clear_req = ctrl_wr && csr_writedata_i[CTRL_CLEAR_BIT];

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d = StRun;
          start_d = 1'b1;
        end
      end
      StRun: begin
        if (test_done_i) begin
          state_d = StDone;
          res_d   = test_result_i;
        end
      end
      StDone: begin
        if (start_req) begin
          state_d = StRun;
          start_d = 1'b1;
        end else if (clear_req) begin
          state_d = StIdle;
          res_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Configuration is locked while a test runs.
  always_comb begin
    param_d = param_q;
    if (wr_acc && (state_q != StRun)) begin
      if (addr == CSR_1_ADDR) param_d.csr_1 = be_merge(param_q.csr_1, csr_writedata_i,
                                                       csr_byteenable_i);
      if (addr == CSR_2_ADDR) param_d.csr_2 = be_merge(param_q.csr_2, csr_writedata_i,
                                                       csr_byteenable_i);
      if (addr == CSR_3_ADDR) param_d.csr_3 = be_merge(param_q.csr_3, csr_writedata_i,
                                                       csr_byteenable_i);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      rdata_d = '0;
      if (addr == STATUS_ADDR) begin
        rdata_d[STATUS_BUSY_BIT]  = (state_q == StRun);
        rdata_d[STATUS_DONE_BIT]  = (state_q == StDone);
        rdata_d[STATUS_ERROR_BIT] = res_q.result_reg[0];
      end
      if (addr == CSR_1_ADDR) rdata_d = param_q.csr_1;
      if (addr == CSR_2_ADDR) rdata_d = param_q.csr_2;
      if (addr == CSR_3_ADDR) rdata_d = param_q.csr_3;
      if (addr_is_res) rdata_d = res_word(res_q, addr - RES_FIRST_ADDR);
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      param_q  <= '0;
      res_q    <= '0;
      start_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      param_q  <= param_d;
      res_q    <= res_d;
      start_q  <= start_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rd_acc;
    end
  end

  assign csr_readdata_o      = rdata_q;
  assign csr_readdatavalid_o = rvalid_q;
  assign csr_waitrequest_o   = wait_req;
  assign start_o             = start_q;
  assign test_param_o        = param_q;

endmodule

// File: tb/tb_mem_checker_csr.sv
// Self-checking bench for mem_checker_csr: directed walk-through of the
// register map and FSM, then random traffic against a behavioural model.
module tb_mem_checker_csr;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   address = '0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  writedata = '0;
  logic [3:0]   byteenable = '0;
  logic [31:0]  readdata;
  logic         readdatavalid;
  logic         waitrequest;
  logic         start;
  logic [95:0]  test_param;
  logic         test_done = 1'b0;
  logic [319:0] test_result = '0;

  always #5 clk = ~clk;

  mem_checker_csr dut (
    .clk_sys_i          (clk),
    .rst_i              (rst),
    .csr_address_i      (address),
    .csr_read_i         (read),
    .csr_write_i        (write),
    .csr_writedata_i    (writedata),
    .csr_byteenable_i   (byteenable),
    .csr_readdata_o     (readdata),
    .csr_readdatavalid_o(readdatavalid),
    .csr_waitrequest_o  (waitrequest),
    .start_o            (start),
    .test_param_o       (test_param),
    .test_done_i        (test_done),
    .test_result_i      (test_result)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Behavioural model of the register file.
  logic [31:0] m_csr [3];
  logic [31:0] m_res [10];
  logic [31:0] stim_res [10];
  bit m_busy, m_done, m_start;

  task automatic check_val(string tag, logic [95:0] got, logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_csr[i] = '0;
    for (int i = 0; i < 10; i++) m_res[i] = '0;
    m_busy = 0; m_done = 0; m_start = 0;
  endtask

  function automatic logic [31:0] model_read(int addr);
    if (addr == 1) return {29'd0, m_res[0][0], m_done, m_busy};
    if (addr >= 2 && addr <= 4) return m_csr[addr-2];
    if (addr >= 5 && addr <= 14) return m_res[addr-5];
    return 32'd0;
  endfunction

  function automatic bit stalls(int addr);
    return (addr == 1) || (addr >= 5 && addr <= 14);
  endfunction

  task automatic model_write(int addr, logic [31:0] data, logic [3:0] be);
    if (addr == 0 && be[0]) begin
      if (data[0]) begin
        if (!m_busy) begin
          m_busy = 1; m_done = 0; m_start = 1;
        end
      end else if (data[1] && m_done) begin
        m_done = 0;
        for (int i = 0; i < 10; i++) m_res[i] = '0;
      end
    end else if (addr >= 2 && addr <= 4 && !m_busy) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_csr[addr-2][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic model_done();
    if (m_busy) begin
      for (int i = 0; i < 10; i++) m_res[i] = stim_res[i];
      m_busy = 0; m_done = 1;
    end
  endtask

  task automatic drive_results();
    for (int i = 0; i < 10; i++) test_result[319-32*i -: 32] = stim_res[i];
  endtask

  task automatic random_results();
    for (int i = 0; i < 10; i++) stim_res[i] = $urandom;
  endtask

  task automatic bus_write(int addr, logic [31:0] data, logic [3:0] be);
    address = 4'(addr); writedata = data; byteenable = be; write = 1'b1;
    #1;
    check_val("wr_waitreq", 96'(waitrequest), 96'd0);
    @(posedge clk);
    model_write(addr, data, be);
    #1;
    write = 1'b0;
    check_val("start_pulse", 96'(start), 96'(m_start));
    m_start = 0;
    check_val("test_param", test_param, {m_csr[0], m_csr[1], m_csr[2]});
  endtask

  task automatic bus_read(int addr);
    logic [31:0] exp;
    address = 4'(addr); read = 1'b1;
    #1;
    check_val("rd_waitreq", 96'(waitrequest), 96'd0);
    exp = model_read(addr);
    @(posedge clk); #1;
    read = 1'b0;
    check_val("rd_valid", 96'(readdatavalid), 96'd1);
    check_val($sformatf("rd_data[%0d]", addr), 96'(readdata), 96'(exp));
    check_val("start_idle", 96'(start), 96'd0);
    @(posedge clk); #1;
    check_val("rd_valid_drop", 96'(readdatavalid), 96'd0);
    check_val("rd_data_hold", 96'(readdata), 96'(exp));
  endtask

  task automatic pulse_done();
    drive_results();
    test_done = 1'b1;
    @(posedge clk);
    model_done();
    #1;
    test_done = 1'b0;
    check_val("start_on_done", 96'(start), 96'd0);
  endtask

  // Read issued in the same cycle as a done pulse.
  task automatic read_with_done(int addr);
    logic [31:0] exp;
    drive_results();
    address = 4'(addr); read = 1'b1; test_done = 1'b1;
    #1;
    check_val("done_waitreq", 96'(waitrequest), 96'(stalls(addr)));
    if (stalls(addr)) begin
      @(posedge clk);
      model_done();
      #1;
      test_done = 1'b0;
      check_val("stall_no_valid", 96'(readdatavalid), 96'd0);
      #1;
      check_val("waitreq_release", 96'(waitrequest), 96'd0);
      exp = model_read(addr);
      @(posedge clk); #1;
    end else begin
      exp = model_read(addr);
      @(posedge clk);
      model_done();
      #1;
      test_done = 1'b0;
    end
    read = 1'b0;
    check_val("done_rd_valid", 96'(readdatavalid), 96'd1);
    check_val($sformatf("done_rd_data[%0d]", addr), 96'(readdata), 96'(exp));
    @(posedge clk); #1;
    check_val("done_rd_drop", 96'(readdatavalid), 96'd0);
  endtask

  initial begin
    int unsigned op, addr;
    logic [31:0] data;
    model_reset();
    for (int i = 0; i < 10; i++) stim_res[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_val("rst_start", 96'(start), 96'd0);
    check_val("rst_rvalid", 96'(readdatavalid), 96'd0);
    check_val("rst_waitreq", 96'(waitrequest), 96'd0);
    check_val("rst_rdata", 96'(readdata), 96'd0);
    check_val("rst_param", test_param, 96'd0);
    for (int a = 0; a < 16; a++) bus_read(a);

    bus_write(3, 32'hA5A5_5A5A, 4'b0101);
    bus_read(3);
    check_val("be_csr2", 96'(readdata), 96'h00A5_005A);

    bus_write(2, 32'd1, 4'hF);
    bus_write(3, 32'd2, 4'hF);
    bus_write(4, 32'd3, 4'hF);
    bus_write(0, 32'd1, 4'hF);
    check_val("param_frozen", test_param, 96'h1_00000002_00000003);
    bus_read(1);
    check_val("status_busy", 96'(readdata), 96'd1);

    bus_write(2, 32'hFF, 4'hF);
    bus_read(2);
    check_val("csr1_locked", 96'(readdata), 96'd1);
    bus_write(0, 32'd1, 4'hF);

    for (int i = 0; i < 10; i++) stim_res[i] = '0;
    stim_res[0] = 32'd1;
    stim_res[9] = 32'h1234;
    read_with_done(5);
    check_val("res_first", 96'(readdata), 96'd1);
    bus_read(14);
    check_val("res_last", 96'(readdata), 96'h1234);
    bus_read(1);
    check_val("status_done", 96'(readdata), 96'b110);

    bus_write(0, 32'd2, 4'hF);
    bus_read(1);
    check_val("status_clear", 96'(readdata), 96'd0);
    bus_read(5);

    bus_write(0, 32'd1, 4'hF);
    rst = 1'b1;
    #1;
    check_val("midrun_rst_start", 96'(start), 96'd0);
    check_val("midrun_rst_param", test_param, 96'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    random_results();
    pulse_done();
    bus_read(1);
    bus_read(5);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      addr = $urandom_range(0, 15);
      data = $urandom;
      if (op <= 3) begin
        if (op == 0) begin
          addr = 0;
          data = 32'($urandom_range(0, 3));
        end
        bus_write(int'(addr), data, 4'($urandom_range(0, 15)));
      end else if (op <= 6) begin
        bus_read(int'(addr));
      end else if (op == 7) begin
        random_results();
        pulse_done();
      end else begin
        random_results();
        read_with_done(int'(addr));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_checker_csr.md
Name: mem_checker_csr

Overview:
- Avalon-MM slave register file: the DUT-side responder to the testbench/host CSR initiator of the memory checker.
- Holds the three test-configuration registers (CSR_1..3) and issues a start pulse to the checker core.
- On the core's done pulse, snapshots the ten 32-bit result registers.
- Serves reads with fixed latency and readdatavalid.

Parameters:
- ADDR_W, 4, word address width of CSR port
- DATA_W, 32, CSR data width (only 32 supported)
- RES_NUM, 10, number of result words captured from core

Ports:
- clk_sys_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- csr_address_i  in  ADDR_W  word address
- csr_read_i  in  1  read request
- csr_write_i  in  1  write request
- csr_writedata_i  in  32  write data
- csr_byteenable_i  in  4  byte lanes for writes
- csr_readdata_o  out  32  read data, valid with readdatavalid
- csr_readdatavalid_o  out  1  read response strobe
- csr_waitrequest_o  out  1  stall current request
- start_o  out  1  one-cycle test start pulse to core
- test_param_o  out  96  {CSR_1, CSR_2, CSR_3}, CSR_1 in MSBs
- test_done_i  in  1  one-cycle completion pulse from core
- test_result_i  in  320  packed results; result_reg at [319:288] ... rd_req_reg at [31:0]

Behaviour:
- Reset: all outputs 0; CSR_1..3 = 0; result regs = 0; FSM = IDLE.
- Address map (word):
  - 0 CTRL: W1 bit0 = start, bit1 = clear; reads 0.
  - 1 STATUS, RO: bit0 busy, bit1 done, bit2 error (= captured result_reg[0]).
  - 2..4 CSR_1..3, RW.
  - 5..14 result regs, RO, same order as the packed bus.
  - 15: reads 0.
- Writes: accepted the cycle csr_write_i=1 and waitrequest=0. Honor byteenable per lane. Writes to RO/unmapped addresses are dropped.
- Reads: accepted the cycle csr_read_i=1 and waitrequest=0. Latency is exactly 1: readdatavalid=1 with data the next cycle. Readdata holds its last value otherwise.
- read and write asserted together is illegal; write takes priority, no read response.
- FSM:
  - IDLE → RUN on a start write: start_o=1 for exactly the cycle after the accepted write; test_param_o frozen.
  - RUN → DONE on test_done_i: capture all 10 result words in the same edge.
  - DONE → RUN on start.
  - DONE → IDLE on clear write: result regs zeroed, done=0.
- busy = (state==RUN); done = (state==DONE).
- While RUN:
  - writes to CSR_1..3 are ignored (config locked);
  - start writes are ignored; no second start_o;
  - clear writes are ignored.
- test_done_i outside RUN is ignored; no capture.
- Waitrequest:
  - asserted combinationally for one cycle when test_done_i=1 and a read targets address 1 or 5..14. The initiator holds the request.
  - The read is accepted the next cycle and returns post-capture data.
  - Otherwise waitrequest=0.
- A start and clear written in the same word: start wins.
- Reset mid-RUN: immediate return to IDLE; start_o low; no capture of a later done.

Decomposition:
- Shared package mem_checker_pkg holds:
  - the address constants (CTRL_ADDR .. RES_LAST_ADDR);
  - CTRL bit indices;
  - the packed result struct typedef matching the 320-bit bus order;
  - the test-param struct typedef.
- No sub-module; the register file and 3-state FSM live in one module.

Test Plan:
- Reset, then read addresses 0..15 → readdatavalid one cycle after each read, all data 0, waitrequest never high.
- Write CSR_2=0xA5A5_5A5A with byteenable 0b0101, then read addr 3 → 0x00A5_005A.
- Write CSR_1..3 = 1,2,3 and CTRL=1 → start_o high exactly one cycle after the write; test_param_o=0x1_00000002_00000003; STATUS reads 1.
- While busy:
  - write CSR_1=0xFF, then read addr 2 → still 1;
  - write CTRL=1 → no start_o.
- Drive test_done_i with result_reg=1, rd_req_reg=0x1234, and simultaneously read addr 5 → waitrequest high 1 cycle, then readdata=1; addr 14 → 0x1234; STATUS=0b110.
- From DONE write CTRL=2 → STATUS=0, results read 0. Assert rst_i mid-RUN → STATUS=0, a later test_done_i is not captured.
